uv_neighbor_cache: RTL and testbench

- Chroma neighbour-sample cache between chroma reconstruction and chroma mode decision.
- On each macroblock (MB) update it stores the reconstructed U/V 8x8 result: bottom rows go to a per-column top-line memory, right columns go to left registers.
- On a fetch for MB (x,y) it presents top_u/top_v/left_u/left_v/top_left_u/top_left_v, with frame-edge substitution, to the chroma mode-decision stage.

---
 rtl/uv_neighbor_cache.sv | 126 ++++++++++++
 tb/tb_uv_neighbor_cache.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uv_neighbor_cache.sv
// Chroma neighbour-sample cache: keeps the top line per MB column and the left column/corner
// of the previous MB, and serves edge-substituted neighbours to chroma mode decision.
module uv_neighbor_cache #(
  parameter int unsigned MAX_MBX    = 256,
  parameter int unsigned BLOCK_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch,
  input  logic                         update,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic [8*16*BLOCK_SIZE-1:0]   rec,
  output logic                         busy,
  output logic [63:0]                  top_u,
  output logic [63:0]                  top_v,
  output logic [63:0]                  left_u,
  output logic [63:0]                  left_v,
  output logic [7:0]                   top_left_u,
  output logic [7:0]                   top_left_v,
  output logic                         fetch_done,
  output logic                         update_done
);

  localparam int unsigned AW         = (MAX_MBX > 1) ? $clog2(MAX_MBX) : 1;
  localparam int unsigned ROW_W      = 64;
  localparam int unsigned U_ROW7_LSB = 8 * 56;
  localparam int unsigned V_ROW7_LSB = 8 * 120;
  localparam int unsigned V_BYTE0    = 64;

  localparam logic [63:0] TOP_DEF  = {8{8'd127}};
  localparam logic [63:0] LEFT_DEF = {8{8'd129}};
  localparam logic [7:0]  TL_TOP   = 8'd127;
  localparam logic [7:0]  TL_LEFT  = 8'd129;

  typedef enum logic [1:0] {IDLE, F_RD, F_CAP, U_WR} state_t;

  state_t               state;
  logic [127:0]         mem [MAX_MBX];
  logic [127:0]         rd_data;
  logic [AW-1:0]        addr;
  logic [63:0]          left_reg_u, left_reg_v;
  logic [63:0]          rec_col_u, rec_col_v;
  logic [7:0]           tl_cur_u, tl_cur_v;
  logic [7:0]           tl_next_u, tl_next_v;
  logic                 y_is_0, x_is_0;
  logic                 unused_inputs;

  assign addr          = AW'(x);
  assign y_is_0        = (y == 10'd0);
  assign x_is_0        = (x == 10'd0);
  assign busy          = (state != IDLE);
  assign unused_inputs = ^{x, rec};

  // Right-hand column (col 7) of each plane becomes the next MB's left neighbour.
  always_comb begin
    rec_col_u = '0;
    rec_col_v = '0;
    for (int r = 0; r < 8; r++) begin
      rec_col_u[8*r +: 8] = rec[8*(r*8 + 7) +: 8];
      rec_col_v[8*r +: 8] = rec[8*(V_BYTE0 + r*8 + 7) +: 8];
    end
  end

  // Top-line memory: bottom rows per MB column, 1-cycle synchronous read.
  always_ff @(posedge clk) begin
    if (rst_n && state == U_WR) begin
      mem[addr] <= {rec[V_ROW7_LSB +: ROW_W], rec[U_ROW7_LSB +: ROW_W]};
    end
    rd_data <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_done  <= 1'b0;
      update_done <= 1'b0;
      top_u       <= TOP_DEF;
      top_v       <= TOP_DEF;
      left_u      <= LEFT_DEF;
      left_v      <= LEFT_DEF;
      top_left_u  <= TL_TOP;
      top_left_v  <= TL_TOP;
      left_reg_u  <= LEFT_DEF;
      left_reg_v  <= LEFT_DEF;
      tl_cur_u    <= TL_TOP;
      tl_cur_v    <= TL_TOP;
      tl_next_u   <= TL_TOP;
      tl_next_v   <= TL_TOP;
    end else begin
      fetch_done  <= 1'b0;
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          // Update has priority; a coincident fetch is dropped.
          if (update)     state <= U_WR;
          else if (fetch) state <= F_RD;
        end
        F_RD: state <= F_CAP;
        F_CAP: begin
          top_u      <= y_is_0 ? TOP_DEF : rd_data[63:0];
          top_v      <= y_is_0 ? TOP_DEF : rd_data[127:64];
          left_u     <= x_is_0 ? LEFT_DEF : left_reg_u;
          left_v     <= x_is_0 ? LEFT_DEF : left_reg_v;
          top_left_u <= y_is_0 ? TL_TOP : (x_is_0 ? TL_LEFT : tl_cur_u);
          top_left_v <= y_is_0 ? TL_TOP : (x_is_0 ? TL_LEFT : tl_cur_v);
          // Top-right of the line above, captured before this column is overwritten.
          tl_next_u  <= y_is_0 ? TL_TOP : rd_data[63:56];
          tl_next_v  <= y_is_0 ? TL_TOP : rd_data[127:120];
          fetch_done <= 1'b1;
          state      <= IDLE;
        end
        U_WR: begin
          left_reg_u  <= rec_col_u;
          left_reg_v  <= rec_col_v;
          tl_cur_u    <= tl_next_u;
          tl_cur_v    <= tl_next_v;
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uv_neighbor_cache.sv
// Scoreboarded bench for uv_neighbor_cache: a byte-level reference model queues the expected
// neighbour set for every done pulse; a monitor pops and compares.
module tb_uv_neighbor_cache;

  localparam int MAX_MBX = 256;
  localparam int REC_W   = 1024;

  typedef struct packed {
    logic        is_fetch;
    logic [63:0] tu, tv, lu, lv;
    logic [7:0]  tlu, tlv;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             fetch, update;
  logic [9:0]       x, y;
  logic [REC_W-1:0] rec;
  logic             busy, fetch_done, update_done;
  logic [63:0]      top_u, top_v, left_u, left_v;
  logic [7:0]       top_left_u, top_left_v;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference model state, kept as plain byte arrays.
  logic [7:0] m_top_u [MAX_MBX][8];
  logic [7:0] m_top_v [MAX_MBX][8];
  bit         written [MAX_MBX];
  logic [7:0] m_left_u [8];
  logic [7:0] m_left_v [8];
  logic [7:0] m_tl_cur_u, m_tl_cur_v, m_tl_next_u, m_tl_next_v;
  exp_t       m_out;

  uv_neighbor_cache #(.MAX_MBX(MAX_MBX), .BLOCK_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .fetch(fetch), .update(update), .x(x), .y(y), .rec(rec),
    .busy(busy), .top_u(top_u), .top_v(top_v), .left_u(left_u), .left_v(left_v),
    .top_left_u(top_left_u), .top_left_v(top_left_v),
    .fetch_done(fetch_done), .update_done(update_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && !busy && (fetch || update))
      assert (x < 10'(MAX_MBX)) else $error("x out of range: %0d", x);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  function automatic logic [7:0] rb(input logic [REC_W-1:0] r, input int i);
    return r[8*i +: 8];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_left_u[k] = 8'd129;
      m_left_v[k] = 8'd129;
    end
    m_tl_cur_u = 8'd127;  m_tl_cur_v = 8'd127;
    m_tl_next_u = 8'd127; m_tl_next_v = 8'd127;
    m_out.is_fetch = 1'b0;
    m_out.tu = {8{8'd127}}; m_out.tv = {8{8'd127}};
    m_out.lu = {8{8'd129}}; m_out.lv = {8{8'd129}};
    m_out.tlu = 8'd127; m_out.tlv = 8'd127;
  endtask

  task automatic model_fetch(input int xx, input int yy);
    exp_t e;
    e.is_fetch = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e.tu[8*k +: 8] = (yy == 0) ? 8'd127 : m_top_u[xx][k];
      e.tv[8*k +: 8] = (yy == 0) ? 8'd127 : m_top_v[xx][k];
      e.lu[8*k +: 8] = (xx == 0) ? 8'd129 : m_left_u[k];
      e.lv[8*k +: 8] = (xx == 0) ? 8'd129 : m_left_v[k];
    end
    e.tlu = (yy == 0) ? 8'd127 : (xx == 0) ? 8'd129 : m_tl_cur_u;
    e.tlv = (yy == 0) ? 8'd127 : (xx == 0) ? 8'd129 : m_tl_cur_v;
    m_tl_next_u = (yy == 0) ? 8'd127 : m_top_u[xx][7];
    m_tl_next_v = (yy == 0) ? 8'd127 : m_top_v[xx][7];
    m_out = e;
    exp_q.push_back(e);
  endtask

  task automatic model_update(input int xx, input logic [REC_W-1:0] r);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      m_top_u[xx][k] = rb(r, 56 + k);
      m_top_v[xx][k] = rb(r, 120 + k);
      m_left_u[k]    = rb(r, k*8 + 7);
      m_left_v[k]    = rb(r, 64 + k*8 + 7);
    end
    written[xx] = 1'b1;
    m_tl_cur_u = m_tl_next_u;
    m_tl_cur_v = m_tl_next_v;
    e = m_out;
    e.is_fetch = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input bit is_fetch, input int lat, input string nm);
    int n = 0;
    bit seen = 1'b0;
    while (n < 10 && !seen) begin
      @(posedge clk); #1;
      n++;
      seen = is_fetch ? fetch_done : update_done;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=none expected=done within 10 cycles", nm);
    end else begin
      chk(nm, 64'(n), 64'(lat));
    end
  endtask

  task automatic do_fetch(input int xx, input int yy);
    model_fetch(xx, yy);
    @(negedge clk);
    x = 10'(xx); y = 10'(yy); fetch = 1'b1;
    @(posedge clk); #1;
    fetch = 1'b0;
    wait_done(1'b1, 2, "fetch_latency");
  endtask

  task automatic do_update(input int xx, input int yy, input logic [REC_W-1:0] r);
    model_update(xx, r);
    @(negedge clk);
    x = 10'(xx); y = 10'(yy); rec = r; update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
    wait_done(1'b0, 1, "update_latency");
  endtask

  function automatic logic [REC_W-1:0] fill(input logic [7:0] u, input logic [7:0] v);
    logic [REC_W-1:0] r;
    for (int i = 0; i < 64; i++) begin
      r[8*i +: 8]        = u;
      r[8*(64 + i) +: 8] = v;
    end
    return r;
  endfunction

  function automatic logic [REC_W-1:0] rnd_rec();
    logic [REC_W-1:0] r;
    for (int w = 0; w < REC_W/32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_fdone"}, 64'(fetch_done), 64'd0);
    chk({tag, "_udone"}, 64'(update_done), 64'd0);
    chk({tag, "_top_u"}, top_u, {8{8'd127}});
    chk({tag, "_top_v"}, top_v, {8{8'd127}});
    chk({tag, "_left_u"}, left_u, {8{8'd129}});
    chk({tag, "_left_v"}, left_v, {8{8'd129}});
    chk({tag, "_tl"}, 64'({top_left_u, top_left_v}), 64'({8'd127, 8'd127}));
  endtask

  // Monitor: every done pulse consumes one expectation in order.
  always @(negedge clk) begin
    if (rst_n && (fetch_done || update_done)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=fd%0b/ud%0b expected=no pulse", fetch_done, update_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_kind", 64'({fetch_done, update_done}), 64'({e.is_fetch, ~e.is_fetch}));
        chk("top_u", top_u, e.tu);
        chk("top_v", top_v, e.tv);
        chk("left_u", left_u, e.lu);
        chk("left_v", left_v, e.lv);
        chk("top_left", 64'({top_left_u, top_left_v}), 64'({e.tlu, e.tlv}));
      end
    end
  end

  initial begin
    logic [REC_W-1:0] r;
    rst_n = 1'b0; fetch = 1'b0; update = 1'b0; x = '0; y = '0; rec = '0;
    for (int i = 0; i < MAX_MBX; i++) written[i] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk_reset_outputs("reset");

    // Frame corner, then left-column propagation.
    do_fetch(0, 0);
    for (int i = 0; i < 128; i++) r[8*i +: 8] = 8'(i);
    do_update(0, 0, r);
    do_fetch(1, 0);
    do_update(1, 0, rnd_rec());

    // Row 0 with flat values, then row 1 neighbours and corner.
    for (int xx = 0; xx < 3; xx++) begin
      do_fetch(xx, 0);
      do_update(xx, 0, fill(8'(10 + xx), 8'(20 + xx)));
    end
    do_fetch(1, 1);
    do_fetch(0, 1);
    do_update(0, 1, fill(8'd50, 8'd60));
    do_fetch(1, 1);
    do_update(1, 1, rnd_rec());

    // Coincident fetch and update: update wins, single busy cycle.
    r = rnd_rec();
    model_update(3, r);
    @(negedge clk);
    x = 10'd3; y = 10'd0; rec = r; fetch = 1'b1; update = 1'b1;
    @(posedge clk); #1;
    fetch = 1'b0; update = 1'b0;
    chk("both_busy", 64'(busy), 64'd1);
    wait_done(1'b0, 1, "both_update_latency");
    chk("both_idle", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);

    // Last memory entry.
    do_fetch(MAX_MBX - 1, 0);
    do_update(MAX_MBX - 1, 0, rnd_rec());
    do_fetch(MAX_MBX - 1, 1);
    do_update(MAX_MBX - 1, 1, rnd_rec());

    // Reset during U_WR drops the write.
    @(negedge clk);
    x = 10'd2; y = 10'd1; rec = rnd_rec(); update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
    chk("uwr_busy", 64'(busy), 64'd1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    do_fetch(2, 1);
    do_update(2, 1, rnd_rec());

    // Randomized MB traffic: fetch then update of the same MB.
    for (int i = 0; i < 40; i++) begin
      int xx, yy;
      xx = ($urandom_range(0, 3) == 0) ? MAX_MBX - 1 : int'($urandom_range(0, 7));
      yy = int'($urandom_range(0, 3));
      if (!written[xx]) yy = 0;
      do_fetch(xx, yy);
      do_update(xx, yy, rnd_rec());
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
